dma_tx_fifo: RTL and testbench

Transmit data FIFO that sits directly downstream of the AHB TX DMA engine. It accepts 32-bit packet words tagged with start/end-of-frame markers, unused-byte counts and flags. It buffers them and serialises each frame as a byte stream to the MAC transmit path. It also drives the space indication that the DMA uses to throttle its AHB data bursts.

---
 rtl/dma_tx_fifo.sv | 181 ++++++++++++++++++
 tb/tb_dma_tx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_tx_fifo.sv
// Transmit FIFO between the AHB TX DMA and the MAC: buffers tagged 32-bit words
// and serialises each frame as bytes, with cut-through start and underrun recovery.
module dma_tx_fifo #(
    parameter int ADDR_WIDTH      = 9,
    parameter int SPACE_MARGIN    = 8,
    parameter int START_THRESHOLD = 64,
    parameter int FCNT_WIDTH      = 5
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  wr_valid,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic [1:0]            wr_unused,
    input  logic                  wr_err,
    input  logic [31:0]           wr_data,
    output logic                  fifo_space,
    output logic                  overflow,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_sop,
    output logic                  tx_eop,
    output logic                  tx_err,
    input  logic                  tx_ready,
    output logic                  underrun,
    output logic [FCNT_WIDTH-1:0] frames_stored
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [FCNT_WIDTH-1:0] FCNT_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_UNDER, S_DRAIN} state_t;

    state_t state, next_state;

    logic [36:0]           mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count, next_count;
    logic [ADDR_WIDTH+1:0] free_words;
    logic [36:0]           rd_word, hold;
    logic [1:0]            byte_idx;
    logic                  full, empty, wr_accept, pop;
    logic                  load_hold, idx_inc, eop_done, drain_eop, ur_detect;
    logic                  last_byte, frame_inc, frame_dec;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (count == DEPTH_W);
    assign empty      = (count == '0);
    assign wr_accept  = wr_valid && !full;
    assign rd_word    = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign next_count = count + (ADDR_WIDTH + 1)'(wr_accept) - (ADDR_WIDTH + 1)'(pop);
    assign free_words = (ADDR_WIDTH + 2)'(DEPTH) - (ADDR_WIDTH + 2)'(next_count);

    // Holding word layout is {err, unused[1:0], eop, sop, data}
    assign last_byte  = hold[33] ? (byte_idx == (2'd3 - hold[35:34])) : (byte_idx == 2'd3);
    assign frame_inc  = wr_accept && wr_eop;
    assign frame_dec  = eop_done || drain_eop;

    always_ff @(posedge HCLK) begin
        if (wr_accept)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_err, wr_unused, wr_eop, wr_sop, wr_data};
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            fifo_space <= 1'b1;
        end else begin
            if (wr_accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            overflow   <= wr_valid && full;
            underrun   <= ur_detect;
            fifo_space <= 32'(free_words) > 32'(SPACE_MARGIN);
        end
    end

    // Saturating frame counter; simultaneous increment and decrement cancel out
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            frames_stored <= '0;
        else if (frame_inc && !frame_dec && frames_stored != FCNT_MAX)
            frames_stored <= frames_stored + 1'b1;
        else if (frame_dec && !frame_inc && frames_stored != '0)
            frames_stored <= frames_stored - 1'b1;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hold     <= '0;
            byte_idx <= '0;
        end else if (load_hold) begin
            hold     <= rd_word;
            byte_idx <= '0;
        end else if (idx_inc) begin
            byte_idx <= byte_idx + 1'b1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // S_UNDER emits the forced error-terminated byte before the rest of the frame is drained
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        load_hold  = 1'b0;
        idx_inc    = 1'b0;
        eop_done   = 1'b0;
        drain_eop  = 1'b0;
        ur_detect  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_sop     = 1'b0;
        tx_eop     = 1'b0;
        tx_err     = 1'b0;
        case (state)
            S_IDLE: begin
                if (frames_stored != '0 || 32'(count) >= 32'(START_THRESHOLD))
                    next_state = S_LOAD;
            end
            S_LOAD: begin
                if (!empty) begin
                    pop        = 1'b1;
                    load_hold  = 1'b1;
                    next_state = S_SEND;
                end else begin
                    ur_detect  = 1'b1;
                    next_state = S_UNDER;
                end
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = hold[{byte_idx, 3'b000} +: 8];
                tx_sop   = hold[32] && (byte_idx == 2'd0);
                tx_eop   = last_byte && hold[33];
                tx_err   = last_byte && hold[33] && hold[36];
                if (tx_ready) begin
                    if (!last_byte) begin
                        idx_inc = 1'b1;
                    end else if (hold[33]) begin
                        eop_done   = 1'b1;
                        next_state = S_IDLE;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        load_hold = 1'b1;
                    end else begin
                        ur_detect  = 1'b1;
                        next_state = S_UNDER;
                    end
                end
            end
            S_UNDER: begin
                tx_valid = 1'b1;
                tx_eop   = 1'b1;
                tx_err   = 1'b1;
                if (tx_ready)
                    next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (rd_word[33]) begin
                        drain_eop  = 1'b1;
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_tx_fifo.sv
// Directed self-checking bench for dma_tx_fifo; a second instance with an
// unreachable start threshold is used to fill the FIFO completely.
module tb_dma_tx_fifo;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        wr_valid, wr_sop, wr_eop, wr_err, tx_ready;
    logic [1:0]  wr_unused;
    logic [31:0] wr_data;
    logic        fifo_space, overflow, tx_valid, tx_sop, tx_eop, tx_err, underrun;
    logic [7:0]  tx_data;
    logic [4:0]  frames_stored;

    logic        f_wr_valid;
    logic [31:0] f_wr_data;
    logic        f_fifo_space, f_overflow, f_tx_valid, f_tx_sop, f_tx_eop, f_tx_err, f_underrun;
    logic [7:0]  f_tx_data;
    logic [4:0]  f_frames_stored;

    int          checks = 0;
    int          errors = 0;
    int          rx_cycles;
    int          ur_count;
    logic [7:0]  exp_bytes [0:299];
    logic        exp_err;

    always #5 HCLK = ~HCLK;

    dma_tx_fifo dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .wr_valid(wr_valid), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_unused(wr_unused),
        .wr_err(wr_err), .wr_data(wr_data),
        .fifo_space(fifo_space), .overflow(overflow),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_err(tx_err), .tx_ready(tx_ready), .underrun(underrun),
        .frames_stored(frames_stored)
    );

    dma_tx_fifo #(.START_THRESHOLD(1024)) dut_full (
        .HCLK(HCLK), .HRESET(HRESET),
        .wr_valid(f_wr_valid), .wr_sop(1'b0), .wr_eop(1'b0), .wr_unused(2'd0),
        .wr_err(1'b0), .wr_data(f_wr_data),
        .fifo_space(f_fifo_space), .overflow(f_overflow),
        .tx_valid(f_tx_valid), .tx_data(f_tx_data), .tx_sop(f_tx_sop), .tx_eop(f_tx_eop),
        .tx_err(f_tx_err), .tx_ready(1'b0), .underrun(f_underrun),
        .frames_stored(f_frames_stored)
    );

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic sop, input logic eop, input logic [1:0] unused,
                                 input logic err, input logic [31:0] data);
        wr_valid  = 1'b1;
        wr_sop    = sop;
        wr_eop    = eop;
        wr_unused = unused;
        wr_err    = err;
        wr_data   = data;
        step();
        wr_valid  = 1'b0;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        wr_unused = 2'd0;
        wr_err    = 1'b0;
    endtask

    // Collects n bytes against exp_bytes; while stalled the pending byte must stay on tx_data
    task automatic receiveFrame(input int n, input bit toggle, input int budget);
        int k = 0;
        int cyc = 0;
        ur_count = 0;
        while (k < n && cyc < budget) begin
            tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (underrun)
                ur_count++;
            if (tx_valid) begin
                checkOutput($sformatf("rx_data[%0d]", k), 32'(tx_data), 32'(exp_bytes[k]));
                checkOutput($sformatf("rx_sop[%0d]", k), 32'(tx_sop), 32'(k == 0));
                checkOutput($sformatf("rx_eop[%0d]", k), 32'(tx_eop), 32'(k == n - 1));
                if (k == n - 1)
                    checkOutput("rx_err", 32'(tx_err), 32'(exp_err));
                if (tx_ready)
                    k++;
            end
            step();
            cyc++;
        end
        tx_ready  = 1'b1;
        rx_cycles = cyc;
        checkOutput("frame_len", 32'(k), 32'(n));
    endtask

    initial begin
        HRESET     = 1'b1;
        wr_valid   = 1'b0;
        wr_sop     = 1'b0;
        wr_eop     = 1'b0;
        wr_err     = 1'b0;
        wr_unused  = 2'd0;
        wr_data    = '0;
        tx_ready   = 1'b0;
        f_wr_valid = 1'b0;
        f_wr_data  = '0;
        step();
        step();
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_fifo_space", 32'(fifo_space), 32'd1);
        checkOutput("rst_frames", 32'(frames_stored), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        HRESET = 1'b0;
        step();
        checkOutput("post_rst_overflow", 32'(overflow), 32'd0);
        checkOutput("post_rst_underrun", 32'(underrun), 32'd0);

        // Five-byte frame with exact latency and back-to-back bytes
        tx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h44332211);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 32'h00000055);
        checkOutput("t1_frames_1", 32'(frames_stored), 32'd1);
        checkOutput("t1_valid_n", 32'(tx_valid), 32'd0);
        step();
        checkOutput("t1_valid_n1", 32'(tx_valid), 32'd0);
        step();
        checkOutput("t1_valid_n2", 32'(tx_valid), 32'd1);
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        exp_bytes[3] = 8'h44; exp_bytes[4] = 8'h55;
        exp_err = 1'b0;
        receiveFrame(5, 1'b0, 20);
        checkOutput("t1_burst_cycles", 32'(rx_cycles), 32'd5);
        checkOutput("t1_frames_0", 32'(frames_stored), 32'd0);
        checkOutput("t1_valid_end", 32'(tx_valid), 32'd0);
        checkOutput("t1_no_underrun", 32'(ur_count), 32'd0);

        // Same frame under 1,0,1,0 backpressure
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h44332211);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 32'h00000055);
        receiveFrame(5, 1'b1, 40);
        step();
        checkOutput("t2_valid_end", 32'(tx_valid), 32'd0);
        checkOutput("t2_frames_0", 32'(frames_stored), 32'd0);

        // Cut-through of 64 words with no eop, ending in an underrun
        for (int i = 0; i < 64; i++)
            applyStimulus(i == 0, 1'b0, 2'd0, 1'b0,
                          {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)});
        for (int j = 0; j < 256; j++)
            exp_bytes[j] = 8'(j);
        exp_bytes[256] = 8'h00;
        exp_err = 1'b1;
        receiveFrame(257, 1'b0, 300);
        checkOutput("t3_underrun_pulses", 32'(ur_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'hAAAAAAAA);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'hBBBBBBBB);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h000000CC);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_drain_quiet[%0d]", i), 32'(tx_valid), 32'd0);
            step();
        end
        checkOutput("t3_drain_frames", 32'(frames_stored), 32'd0);

        // Error-flagged frame right after the drain must arrive intact
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h78563412);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b1, 32'hF0DEBC9A);
        exp_bytes[0] = 8'h12; exp_bytes[1] = 8'h34; exp_bytes[2] = 8'h56; exp_bytes[3] = 8'h78;
        exp_bytes[4] = 8'h9A; exp_bytes[5] = 8'hBC; exp_bytes[6] = 8'hDE; exp_bytes[7] = 8'hF0;
        exp_err = 1'b1;
        receiveFrame(8, 1'b0, 30);
        checkOutput("t4_no_underrun", 32'(ur_count), 32'd0);
        checkOutput("t4_frames_0", 32'(frames_stored), 32'd0);

        // Fill the second instance: space drops at 504 words, write 513 overflows
        f_wr_valid = 1'b1;
        for (int i = 1; i <= 513; i++) begin
            f_wr_data = 32'(i);
            step();
            if (i == 503)
                checkOutput("t5_space_503", 32'(f_fifo_space), 32'd1);
            if (i == 504)
                checkOutput("t5_space_504", 32'(f_fifo_space), 32'd0);
            if (i == 512)
                checkOutput("t5_overflow_512", 32'(f_overflow), 32'd0);
        end
        f_wr_valid = 1'b0;
        checkOutput("t5_overflow_513", 32'(f_overflow), 32'd1);
        step();
        checkOutput("t5_overflow_clear", 32'(f_overflow), 32'd0);
        f_wr_valid = 1'b1;
        step();
        f_wr_valid = 1'b0;
        checkOutput("t5_still_full", 32'(f_overflow), 32'd1);
        step();
        checkOutput("t5_overflow_pulse", 32'(f_overflow), 32'd0);
        checkOutput("t5_space_full", 32'(f_fifo_space), 32'd0);
        checkOutput("t5_no_tx", 32'(f_tx_valid), 32'd0);

        // Reset after two bytes of a three-word frame
        tx_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h44332211);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h88776655);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000CC99);
        for (int i = 0; i < 10 && !tx_valid; i++)
            step();
        checkOutput("t6_byte0", 32'(tx_data), 32'h11);
        step();
        checkOutput("t6_byte1", 32'(tx_data), 32'h22);
        step();
        HRESET = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(tx_valid), 32'd0);
        checkOutput("t6_rst_data", 32'(tx_data), 32'd0);
        checkOutput("t6_rst_sop", 32'(tx_sop), 32'd0);
        checkOutput("t6_rst_eop", 32'(tx_eop), 32'd0);
        checkOutput("t6_rst_err", 32'(tx_err), 32'd0);
        checkOutput("t6_rst_frames", 32'(frames_stored), 32'd0);
        checkOutput("t6_rst_space", 32'(fifo_space), 32'd1);
        checkOutput("t6_rst_full_space", 32'(f_fifo_space), 32'd1);
        step();
        HRESET = 1'b0;
        step();
        checkOutput("t6_idle_after", 32'(tx_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'hD4C3B2A1);
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 32'h000000E5);
        exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3;
        exp_bytes[3] = 8'hD4; exp_bytes[4] = 8'hE5;
        exp_err = 1'b0;
        receiveFrame(5, 1'b0, 20);
        step();
        checkOutput("t6_valid_end", 32'(tx_valid), 32'd0);
        checkOutput("t6_frames_0", 32'(frames_stored), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
